// File: rtl/ped_button_conditioner.sv
// Pedestrian push-button front end: sync + debounce, one held request per accepted press,
// post-acknowledge lockout, and a saturating accepted-press counter.
module ped_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LOCKOUT_CYCLES  = 64,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             btn_raw,
  input  logic             ped_ack,
  output logic             ped_req,
  output logic             btn_clean,
  output logic             in_lockout,
  output logic [CNT_W-1:0] press_count
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES);
  localparam int LKW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LKW-1:0] LK_LOAD = LKW'(LOCKOUT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_LOCK = 2'd2;

  logic             s1_q, s2_q;
  logic [DBW-1:0]   db_cnt_q, db_cnt_d;
  logic             clean_q, clean_d;
  logic             clean_dly_q;
  logic [1:0]       state_q, state_d;
  logic [LKW-1:0]   lk_cnt_q, lk_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             lock_q, lock_d;
  logic             press_evt;

  // Any cycle where the synchronized level agrees with the clean level restarts the stability window.
  always_comb begin
    db_cnt_d = db_cnt_q;
    clean_d  = clean_q;
    if (s2_q == clean_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      clean_d  = s2_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + DBW'(1);
    end
  end

  assign press_evt = clean_q & ~clean_dly_q & ena;

  always_comb begin
    state_d  = state_q;
    lk_cnt_d = lk_cnt_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (press_evt) begin
          state_d = ST_PEND;
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_PEND: begin
        if (ped_ack) begin
          state_d  = ST_LOCK;
          lk_cnt_d = LK_LOAD;
        end
      end
      ST_LOCK: begin
        if (lk_cnt_q == '0) state_d = ST_IDLE;
        else                lk_cnt_d = lk_cnt_q - LKW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    req_d  = (state_d == ST_PEND);
    lock_d = (state_d == ST_LOCK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      db_cnt_q    <= '0;
      clean_q     <= 1'b0;
      clean_dly_q <= 1'b0;
      state_q     <= ST_IDLE;
      lk_cnt_q    <= '0;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      lock_q      <= 1'b0;
    end else begin
      s1_q        <= btn_raw;
      s2_q        <= s1_q;
      db_cnt_q    <= db_cnt_d;
      clean_q     <= clean_d;
      clean_dly_q <= clean_q;
      state_q     <= state_d;
      lk_cnt_q    <= lk_cnt_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      lock_q      <= lock_d;
    end
  end

  assign ped_req     = req_q;
  assign btn_clean   = clean_q;
  assign in_lockout  = lock_q;
  assign press_count = cnt_q;

endmodule
